// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding,
// master (owner) encoding and the width of the burst beat counter.
package dmem_arb_pkg;

    localparam int BEAT_W = 4;
    localparam logic [BEAT_W-1:0] BEAT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant decision for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects a round-robin tie-break in IDLE;
// when it is undefined, m0 wins every IDLE tie.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  state_e            state,
    input  logic [BEAT_W-1:0] beat_cnt,
    input  owner_e            last_srv,
    input  logic [1:0]        req,
    output logic [1:0]        gnt
);

    localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(BURST_MAX);

    // Pick at most one master: the current owner keeps the bus until its
    // burst is spent while the other master waits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        unique case (state)
            IDLE: begin
                if (req == 2'b01) begin
                    gnt = 2'b01;
                end else if (req == 2'b10) begin
                    gnt = 2'b10;
                end else if (req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                    gnt = (last_srv == M0) ? 2'b10 : 2'b01;
`else
                    gnt = 2'b01;
`endif
                end
            end
            OWN0: begin
                if (req[0] && ((beat_cnt < BURST_LIM) || !req[1])) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end
            end
            OWN1: begin
                if (req[1] && ((beat_cnt < BURST_LIM) || !req[0])) begin
                    gnt = 2'b10;
                end else if (req[0]) begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

`ifndef DMEM_ARB_RR_EN
    // last_srv only steers the round-robin tie-break.
    logic unused_last_srv;
    assign unused_last_srv = last_srv;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-cycle MIPS data memory.
// One access per clock, bounded bursts, registered read data returned to
// the owning master one cycle after the access.
// Build option: DMEM_ARB_RR_EN (round-robin IDLE tie-break, applied in dmem_arb_pick).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    state_e            state, state_n;
    logic [BEAT_W-1:0] beat_cnt, beat_n;
    owner_e            last_srv, last_n;
    logic [1:0]        pick_gnt;
    logic [1:0]        gnt;
    logic [1:0]        rd_acc;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    dmem_arb_pick #(
        .BURST_MAX (BURST_MAX)
    ) u_pick (
        .state    (state),
        .beat_cnt (beat_cnt),
        .last_srv (last_srv),
        .req      ({m1_req, m0_req}),
        .gnt      (pick_gnt)
    );

    // Reset suppresses any grant, so an access in flight when rst rises is dropped.
    assign gnt    = rst ? 2'b00 : pick_gnt;
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    assign rd_acc = {gnt[1] & ~m1_we, gnt[0] & ~m0_we};

    assign m0_rvalid = rvalid_q[0] & ~rst;
    assign m1_rvalid = rvalid_q[1] & ~rst;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    // Steer the granted master onto the memory pins; drive zeros when idle.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (gnt[0]) begin
            mem_we = m0_we;
            mem_a  = m0_addr;
            mem_wd = m0_wdata;
        end else if (gnt[1]) begin
            mem_we = m1_we;
            mem_a  = m1_addr;
            mem_wd = m1_wdata;
        end
    end

    // Next owner, burst length and most-recently-served master.
    always_comb begin
        state_n = IDLE;
        beat_n  = '0;
        last_n  = last_srv;
        if (gnt[0]) begin
            state_n = OWN0;
            last_n  = M0;
            beat_n  = (state != OWN0)      ? BEAT_W'(1) :
                      (beat_cnt == BEAT_SAT) ? beat_cnt : beat_cnt + BEAT_W'(1);
        end else if (gnt[1]) begin
            state_n = OWN1;
            last_n  = M1;
            beat_n  = (state != OWN1)      ? BEAT_W'(1) :
                      (beat_cnt == BEAT_SAT) ? beat_cnt : beat_cnt + BEAT_W'(1);
        end
    end

    // Arbitration state and registered read return.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last_srv <= M1;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            last_srv <= last_n;
            rvalid_q <= rd_acc;
            if (rd_acc[0]) rdata0_q <= mem_rd;
            if (rd_acc[1]) rdata1_q <= mem_rd;
        end
    end

endmodule
